// File: rtl/decode_stage_hz.sv
// Decode stage for the 16-bit MISC-V pipeline. Contains the IF/ID register, a
// register file with write-through, branch/JR resolution and hazard detection.
module decode_stage_hz #(
    parameter int unsigned XLEN     = 16,
    parameter logic [2:0]  OPC_LOAD = 3'd2,
    parameter logic [2:0]  OPC_BEQ  = 3'd3,
    parameter logic [2:0]  OPC_BNE  = 3'd4,
    parameter logic [2:0]  OPC_BLT  = 3'd5,
    parameter logic [2:0]  OPC_JR   = 3'd6,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [XLEN-1:0]  if_pcp2,
    input  logic [15:0]      if_ir,
    input  logic             if_valid,
    input  logic             flush_in,
    input  logic             wb_we,
    input  logic [2:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [2:0]       ex_rd,
    input  logic [1:0]       fwd1_sel,
    input  logic [1:0]       fwd2_sel,
    input  logic [XLEN-1:0]  fwd_exmem,
    input  logic [XLEN-1:0]  fwd_memwb,
    output logic             stall,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_pcp2,
    output logic [15:0]      id_ir,
    output logic [2:0]       rs1,
    output logic [2:0]       rs2,
    output logic [2:0]       rd,
    output logic [XLEN-1:0]  arg1,
    output logic [XLEN-1:0]  arg2,
    output logic [XLEN-1:0]  arg3,
    output logic [XLEN-1:0]  imm,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    logic [XLEN-1:0]  pc_r;
    logic [XLEN-1:0]  pcp2_r;
    logic [15:0]      ir_r;
    logic             valid_r;
    logic [XLEN-1:0]  regs_r [0:7];
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] redirect_cnt_r;

    logic [2:0]       opc_s;
    logic             is_br_s;
    logic             is_jr_s;
    logic [XLEN-1:0]  c1_s;
    logic [XLEN-1:0]  c2_s;
    logic             taken_s;
    logic             load_use_s;
    logic             br_dep_s;
    logic             stall_s;
    logic             redirect_s;
    logic [XLEN-1:0]  imm_s;

    // Register read with r0 hardwired to zero and same-cycle write-through.
    function automatic logic [XLEN-1:0] rf_read(input logic [2:0] addr);
        logic [XLEN-1:0] val;
        if (addr == 3'd0) begin
            val = {XLEN{1'b0}};
        end else if (wb_we && (wb_addr == addr)) begin
            val = wb_data;
        end else begin
            val = regs_r[addr];
        end
        return val;
    endfunction

    // Instruction field decode and register operand reads.
    always_comb begin
        opc_s   = ir_r[2:0];
        is_br_s = 1'b0;
        is_jr_s = 1'b0;
        case (opc_s)
            OPC_BEQ, OPC_BNE, OPC_BLT: is_br_s = 1'b1;
            OPC_JR:                    is_jr_s = 1'b1;
            default: begin
                is_br_s = 1'b0;
                is_jr_s = 1'b0;
            end
        endcase
        rs1   = ir_r[8:6];
        rs2   = ir_r[11:9];
        rd    = ir_r[5:3];
        arg1  = rf_read(ir_r[8:6]);
        arg2  = rf_read(ir_r[11:9]);
        arg3  = rf_read(ir_r[5:3]);
        imm_s = {{(XLEN-8){ir_r[15]}}, ir_r[15:12], ir_r[5:3], 1'b0};
    end

    // Comparator operand forwarding muxes; selects 0 and 3 both use the regfile.
    always_comb begin
        case (fwd1_sel)
            2'd1:    c1_s = fwd_exmem;
            2'd2:    c1_s = fwd_memwb;
            default: c1_s = arg1;
        endcase
        case (fwd2_sel)
            2'd1:    c2_s = fwd_exmem;
            2'd2:    c2_s = fwd_memwb;
            default: c2_s = arg2;
        endcase
    end

    // Hazard detection, branch condition and redirect target.
    always_comb begin
        if (is_jr_s) begin
            load_use_s = ex_mem_read && (ex_rd != 3'd0) && (ex_rd == rd);
        end else begin
            load_use_s = ex_mem_read && (ex_rd != 3'd0) &&
                         ((ex_rd == rs1) || (ex_rd == rs2));
        end
        br_dep_s = ex_reg_write && (ex_rd != 3'd0) &&
                   ((is_br_s && ((ex_rd == rs1) || (ex_rd == rs2))) ||
                    (is_jr_s && (ex_rd == rd)));
        stall_s = valid_r && (load_use_s || br_dep_s);

        case (opc_s)
            OPC_BEQ: taken_s = (c1_s == c2_s);
            OPC_BNE: taken_s = (c1_s != c2_s);
            OPC_BLT: taken_s = ($signed(c1_s) < $signed(c2_s));
            OPC_JR:  taken_s = 1'b1;
            default: taken_s = 1'b0;
        endcase
        redirect_s = valid_r && !stall_s && taken_s;

        if (is_jr_s) begin
            redirect_pc = {arg3[XLEN-1:1], 1'b0};
        end else begin
            redirect_pc = pc_r + imm_s;
        end
    end

    // IF/ID pipeline register: flush/redirect beats stall, stall beats load.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pc_r    <= {XLEN{1'b0}};
            pcp2_r  <= {XLEN{1'b0}};
            ir_r    <= 16'h0000;
            valid_r <= 1'b0;
        end else if (redirect_s || flush_in) begin
            ir_r    <= 16'h0000;
            valid_r <= 1'b0;
        end else if (stall_s) begin
            valid_r <= valid_r;
        end else begin
            pc_r    <= if_pc;
            pcp2_r  <= if_pcp2;
            ir_r    <= if_ir;
            valid_r <= if_valid;
        end
    end

    // Register file write port; r0 is never written.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_we && (wb_addr != 3'd0)) begin
            regs_r[wb_addr] <= wb_data;
        end else begin
            regs_r[0] <= {XLEN{1'b0}};
        end
    end

    // Saturating stall and redirect event counters.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            stall_cnt_r    <= {CNT_W{1'b0}};
            redirect_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (redirect_s && (redirect_cnt_r != {CNT_W{1'b1}})) begin
                redirect_cnt_r <= redirect_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stall        = stall_s;
    assign redirect     = redirect_s;
    assign id_valid     = valid_r && !stall_s;
    assign id_pc        = pc_r;
    assign id_pcp2      = pcp2_r;
    assign id_ir        = ir_r;
    assign imm          = imm_s;
    assign stall_cnt    = stall_cnt_r;
    assign redirect_cnt = redirect_cnt_r;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed self-checking bench for decode_stage_hz with hand-computed
// expectations; CNT_W is narrowed so counter saturation is reachable quickly.
module tb_decode_stage_hz;

    localparam int XLEN  = 16;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             Reset;
    logic [XLEN-1:0]  if_pc, if_pcp2, wb_data, fwd_exmem, fwd_memwb;
    logic [15:0]      if_ir;
    logic             if_valid, flush_in, wb_we, ex_mem_read, ex_reg_write;
    logic [2:0]       wb_addr, ex_rd;
    logic [1:0]       fwd1_sel, fwd2_sel;
    logic             stall, id_valid, redirect;
    logic [XLEN-1:0]  id_pc, id_pcp2, arg1, arg2, arg3, imm, redirect_pc;
    logic [15:0]      id_ir;
    logic [2:0]       rs1, rs2, rd;
    logic [CNT_W-1:0] stall_cnt, redirect_cnt;

    int n_vec = 0;
    int n_bad = 0;

    decode_stage_hz #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .Reset(Reset),
        .if_pc(if_pc), .if_pcp2(if_pcp2), .if_ir(if_ir), .if_valid(if_valid),
        .flush_in(flush_in),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
        .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb),
        .stall(stall), .id_valid(id_valid),
        .id_pc(id_pc), .id_pcp2(id_pcp2), .id_ir(id_ir),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .arg1(arg1), .arg2(arg2), .arg3(arg3), .imm(imm),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );

    // Free-running clock, 10 time-unit period.
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [15:0] ir, input logic [15:0] pc);
        if_ir    = ir;
        if_pc    = pc;
        if_pcp2  = pc + 16'd2;
        if_valid = 1'b1;
    endtask

    initial begin
        Reset = 1'b0;
        if_pc = 16'h0000; if_pcp2 = 16'h0000; if_ir = 16'h0000; if_valid = 1'b0;
        flush_in = 1'b0; wb_we = 1'b0; wb_addr = 3'd0; wb_data = 16'h0000;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 3'd0;
        fwd1_sel = 2'd0; fwd2_sel = 2'd0; fwd_exmem = 16'h0000; fwd_memwb = 16'h0000;
        #3;
        check_val("rst_stall", stall, 0);
        check_val("rst_redirect", redirect, 0);
        check_val("rst_id_valid", id_valid, 0);
        check_val("rst_id_ir", id_ir, 0);
        check_val("rst_cnts", {stall_cnt, redirect_cnt}, 0);
        #9 Reset = 1'b1;

        // r3 = 0x1234, attempted r0 = 0xFFFF
        wb_we = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
        tick();
        wb_addr = 3'd0; wb_data = 16'hFFFF;
        tick();
        wb_we = 1'b0;
        fetch(16'h00C8, 16'h0010);          // rs1=3 rs2=0 rd=1 opc=0
        tick();
        check_val("rd_r3", arg1, 16'h1234);
        check_val("rd_r0", arg2, 16'h0000);
        check_val("id_valid", id_valid, 1);
        check_val("id_pc", id_pc, 16'h0010);
        check_val("id_pcp2", id_pcp2, 16'h0012);

        // same-cycle write-through on rs2=2
        fetch(16'h04C8, 16'h0010);          // rs1=3 rs2=2 rd=1
        tick();
        wb_we = 1'b1; wb_addr = 3'd2; wb_data = 16'hBEEF;
        #1;
        check_val("wthru_arg2", arg2, 16'hBEEF);
        tick();
        wb_we = 1'b0;
        #1;
        check_val("rf_arg2", arg2, 16'hBEEF);

        // load-use on rs1
        ex_mem_read = 1'b1; ex_rd = 3'd0;
        #1;
        check_val("lu_rd0_nostall", stall, 0);
        ex_rd = 3'd3;
        fetch(16'h0008, 16'h0020);
        #1;
        check_val("lu_stall", stall, 1);
        check_val("lu_id_valid", id_valid, 0);
        tick();
        check_val("lu_hold_pc", id_pc, 16'h0010);
        check_val("lu_hold_ir", id_ir, 16'h04C8);
        check_val("lu_stall_cnt", stall_cnt, 1);
        ex_mem_read = 1'b0;
        #1;
        check_val("lu_release", {stall, id_valid}, 2'b01);

        // BEQ at 0x40, imm=-4, c1 fwd 7, r4 = 7
        fetch(16'hF873, 16'h0040);          // func=F rs2=4 rs1=1 rd=6 opc=3
        wb_we = 1'b1; wb_addr = 3'd4; wb_data = 16'h0007;
        tick();
        wb_we = 1'b0;
        fwd1_sel = 2'd1; fwd_exmem = 16'h0007;
        #1;
        check_val("beq_imm", imm, 16'hFFFC);
        check_val("beq_taken", redirect, 1);
        check_val("beq_target", redirect_pc, 16'h003C);
        fwd_exmem = 16'h0008;
        #1;
        check_val("beq_not_taken", redirect, 0);
        fwd_exmem = 16'h0007;
        ex_reg_write = 1'b1; ex_rd = 3'd1;
        #1;
        check_val("brdep_stall", {stall, redirect, id_valid}, 3'b100);
        ex_reg_write = 1'b0; ex_rd = 3'd0;
        fetch(16'h0008, 16'h0044);
        tick();
        check_val("beq_bubble", {id_valid, redirect}, 0);
        check_val("beq_bubble_ir", id_ir, 16'h0000);
        check_val("beq_bubble_pc", id_pc, 16'h0040);
        check_val("redir_cnt1", redirect_cnt, 1);

        // BLT signed: 0xFFFF < 0x0001, imm=+4 at 0x50
        fwd1_sel = 2'd0;
        fetch(16'h0855, 16'h0050);          // rs2=4 rs1=1 rd=2 opc=5
        tick();
        fwd1_sel = 2'd1; fwd_exmem = 16'hFFFF;
        fwd2_sel = 2'd2; fwd_memwb = 16'h0001;
        #1;
        check_val("blt_taken", redirect, 1);
        check_val("blt_target", redirect_pc, 16'h0054);
        wb_we = 1'b1; wb_addr = 3'd5; wb_data = 16'h0101;
        tick();
        wb_we = 1'b0; fwd1_sel = 2'd0; fwd2_sel = 2'd0;
        check_val("redir_cnt2", redirect_cnt, 2);

        // JR through r5 = 0x0101
        fetch(16'h002E, 16'h0060);          // rd=5 opc=6
        tick();
        check_val("jr_taken", redirect, 1);
        check_val("jr_target", redirect_pc, 16'h0100);
        ex_reg_write = 1'b1; ex_rd = 3'd5;
        #1;
        check_val("jr_brdep", {stall, redirect}, 2'b10);
        ex_reg_write = 1'b0; ex_mem_read = 1'b1;
        #1;
        check_val("jr_loaduse", {stall, redirect}, 2'b10);

        // stall and flush together: flush wins
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0; ex_mem_read = 1'b0;
        check_val("flush_ir", id_ir, 16'h0000);
        check_val("flush_valid", id_valid, 0);
        check_val("flush_pc", id_pc, 16'h0060);
        check_val("cnts_after_flush", {stall_cnt, redirect_cnt}, {4'd2, 4'd2});

        // stall counter saturation
        fetch(16'h00C8, 16'h0070);
        tick();
        ex_mem_read = 1'b1; ex_rd = 3'd3;
        for (int i = 0; i < 13; i++) tick();
        check_val("sat_reach", stall_cnt, 4'hF);
        for (int i = 0; i < 3; i++) tick();
        check_val("sat_hold", stall_cnt, 4'hF);
        check_val("sat_pc_held", id_pc, 16'h0070);

        // async reset mid-stall
        Reset = 1'b0;
        #1;
        check_val("rst_mid_stall", {stall, id_valid}, 0);
        check_val("rst_mid_cnt", stall_cnt, 0);
        check_val("rst_mid_ir", id_ir, 0);
        ex_mem_read = 1'b0; ex_rd = 3'd0;
        fetch(16'h04C8, 16'h0080);
        #1 Reset = 1'b1;
        tick();
        check_val("post_rst_ir", id_ir, 16'h04C8);
        check_val("post_rst_valid", id_valid, 1);
        check_val("post_rst_rf", arg1, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage_hz.md
Name: decode_stage_hz

Overview:
Parametrised next-generation decode stage for the 16-bit MISC-V pipeline. It contains four parts: the IF/ID pipeline register with stall/flush, a register file with write-through bypass, branch/jump resolution in ID with forwarded comparator operands, and load-use and branch-dependency hazard detection. It sits between fetch and the ID/EX register. Instruction format is fixed: opcode ir[2:0], rd ir[5:3], rs1 ir[8:6], rs2 ir[11:9], func ir[15:12].

Parameters:
XLEN, 16, data/PC width (>=16)
OPC_LOAD, 3'd2, load opcode
OPC_BEQ, 3'd3, branch-if-equal opcode
OPC_BNE, 3'd4, branch-if-not-equal opcode
OPC_BLT, 3'd5, signed branch-if-less-than opcode
OPC_JR, 3'd6, jump to R[ir[5:3]]
CNT_W, 16, stall/redirect counter width

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
if_pc  in  XLEN  PC of fetched instruction
if_pcp2  in  XLEN  PC+2 of fetched instruction
if_ir  in  16  fetched instruction
if_valid  in  1  fetched instruction valid
flush_in  in  1  external flush of IF/ID
wb_we  in  1  register-file write enable
wb_addr  in  3  write address
wb_data  in  XLEN  write data
ex_mem_read  in  1  ID/EX instruction is a load
ex_reg_write  in  1  ID/EX instruction writes a register
ex_rd  in  3  ID/EX destination
fwd1_sel  in  2  comparator op1 select: 0 regfile, 1 fwd_exmem, 2 fwd_memwb, 3 regfile
fwd2_sel  in  2  same selection for op2
fwd_exmem  in  XLEN  EX/MEM forward value
fwd_memwb  in  XLEN  MEM/WB forward value
stall  out  1  hold PC and IF/ID
id_valid  out  1  ID instruction valid to ID/EX (0 = bubble)
id_pc  out  XLEN  registered PC
id_pcp2  out  XLEN  registered PC+2
id_ir  out  16  registered instruction
rs1, rs2, rd  out  3 each  register fields
arg1, arg2, arg3  out  XLEN  R[rs1], R[rs2], R[rd] after bypass
imm  out  XLEN  branch immediate
redirect  out  1  taken branch/jump in ID
redirect_pc  out  XLEN  target
stall_cnt  out  CNT_W  stall cycles counted
redirect_cnt  out  CNT_W  redirects counted

Behaviour:
- Reset low (async) sets: IF/ID pc=0, pcp2=0, ir=0, valid=0; all 8 registers=0; both counters=0. Consequently stall=0, redirect=0, id_valid=0.
- IF/ID update on the CLK edge, in priority order:
  - redirect=1 or flush_in=1: load bubble (ir=0, valid=0, pc/pcp2 unchanged). Flush wins over stall.
  - stall=1: hold all fields.
  - Otherwise: load if_* fields.
- Register file:
  - Written on the CLK edge when wb_we=1 and wb_addr!=0.
  - r0 always reads 0.
  - Reads are combinational. Same-cycle write-through: when wb_we=1, wb_addr==read addr and the address is !=0, the read returns wb_data.
- imm: sign-extend {ir[15:12], ir[5:3], 1'b0} to XLEN.
- Branch resolution (combinational, qualified by valid and !stall):
  - BEQ: taken if c1==c2. BNE: taken if c1!=c2. BLT: taken if $signed(c1)<$signed(c2).
  - c1/c2 are the fwd-selected arg1/arg2.
  - Branch target = id_pc+imm, modulo 2^XLEN.
  - JR: always taken; target = arg3 with bit0 cleared.
- Hazards (valid=1 required):
  - Load-use: ex_mem_read=1, ex_rd!=0, and ex_rd equals rs1 or rs2 (non-JR) or rd (JR).
  - Branch-dependency: branch/JR, ex_reg_write=1, ex_rd!=0, and ex_rd matches a compared/jump register.
  - Either hazard gives stall=1, id_valid=0, redirect=0.
- id_valid = valid & !stall.
- Counters:
  - stall_cnt increments on each edge with stall=1.
  - redirect_cnt increments on each edge with redirect=1.
  - Both saturate at all-ones.
- Reset asserted mid-stall or mid-redirect clears state immediately. The first edge after release loads if_*.

Test Plan:
- Reset release, wb writes r3=0x1234 and r0=0xFFFF, if_ir reads rs1=3 -> arg1=0x1234; r0 reads 0.
- wb_we=1, wb_addr=2, wb_data=0xBEEF in the same cycle ID reads rs2=2 -> arg2=0xBEEF the same cycle.
- Load-use: ex_mem_read=1, ex_rd=1, ID rs1=1 -> stall=1 for 1 cycle, id_valid=0, IF/ID held. stall_cnt=1.
- BEQ at id_pc=0x0040, imm=-4, fwd1_sel=1, fwd_exmem=7, arg2=7 -> redirect=1, redirect_pc=0x003C. Next cycle id_valid=0, ir=0.
- BLT with c1=0xFFFF, c2=0x0001 -> taken (signed). JR with R[5]=0x0101 -> redirect_pc=0x0100.
- stall=1 and flush_in=1 together -> bubble loaded. Counter preset near all-ones -> saturates, no wrap.
